// File: rtl/mac_seq.sv
// mac_seq: iterative 32x32 multiply-accumulate, 8 multiplier bits per cycle with early termination
module mac_seq #(
  parameter int CHUNK   = 8,
  parameter int MAX_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] acc,
  input  logic        acc_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        flag_n,
  output logic        flag_z,
  output logic [2:0]  mul_cycles
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, p_q, p_d, sum_q, sum_d;
  logic [1:0]  k_q, k_d;
  logic        fn_q, fn_d, fz_q, fz_d;
  logic [2:0]  cyc_q, cyc_d;
  logic [5:0]  sh, sh_n;
  logic [7:0]  chunk;
  logic [31:0] p_nxt;
  logic        last;
  assign sh    = {1'b0, k_q, 3'b000};
  assign sh_n  = sh + 6'd8;
  assign chunk = 8'(b_q >> sh);
  assign p_nxt = p_q + ((a_q * {24'd0, chunk}) << sh);
  // shifting by 32 on the final chunk yields zero, so k==3 also satisfies the remainder test
  assign last  = (k_q == 2'd3) || ((b_q >> sh_n) == 32'd0);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    k_d     = k_q;
    sum_d   = sum_q;
    fn_d    = fn_q;
    fz_d    = fz_q;
    cyc_d   = cyc_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = in1;
      b_d     = in2;
      p_d     = acc_en ? acc : 32'd0;
      k_d     = 2'd0;
      state_d = MUL;
    end else if (state_q == MUL) begin
      p_d = p_nxt;
      k_d = k_q + 2'd1;
      if (last) begin
        sum_d   = p_nxt;
        fn_d    = p_nxt[31];
        fz_d    = p_nxt == 32'd0;
        cyc_d   = {1'b0, k_q} + 3'd1;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      fn_q    <= 1'b0;
      fz_q    <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      fn_q    <= fn_d;
      fz_q    <= fz_d;
      cyc_q   <= cyc_d;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign sum        = sum_q;
  assign flag_n     = fn_q;
  assign flag_z     = fz_q;
  assign mul_cycles = cyc_q;
endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Iterative multiply-accumulate sequencer that sits directly upstream of the combinational MAC datapath stage.
- Accepts an operand set (Rm, Rs, optional accumulator) through a valid/ready handshake.
- Consumes the multiplier Rs 8 bits per cycle, ARM7TDMI-style, with early termination.
- Returns the 32-bit product/sum plus N/Z flags through a second valid/ready handshake.

Parameters:
- CHUNK, 8, multiplier bits consumed per MUL cycle; only 8 is supported.
- MAX_CYC, 4, maximum MUL cycles (32/CHUNK).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  sequencer can accept operands.
- in1  input  32  multiplicand (Rm).
- in2  input  32  multiplier (Rs).
- acc  input  32  accumulate value (Rn).
- acc_en  input  1  1 = MLA (add acc), 0 = MUL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  32  result, low 32 bits.
- flag_n  output  1  sum[31].
- flag_z  output  1  sum == 0.
- mul_cycles  output  3  MUL cycles used for the last result, 1..4.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, sum=0, flag_n=0, flag_z=0, mul_cycles=0, state=IDLE.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A=in1 and B=in2; set P=acc_en?acc:0, k=0; go to MUL.
- MUL:
  - in_ready=0.
  - Each cycle: P <= P + ((A * B[8k+7:8k]) << 8k), truncated mod 2^32; k <= k+1.
  - Terminate after the cycle that consumes chunk k when B[31:8(k+1)]==0 or k==3. Then go to DONE and set mul_cycles=k+1.
  - Always at least 1 MUL cycle, including B==0.
- DONE:
  - out_valid=1. sum, flag_n and flag_z are registered and stable.
  - in_ready=0.
  - On out_ready: out_valid<=0, state=IDLE.
  - sum, flags and mul_cycles hold their last values until the next DONE.
- Latency: accept edge, then 1..4 MUL cycles, then out_valid asserted the cycle after the final MUL edge. Total accept-to-out_valid = mul_cycles+1 edges.
- No new operand accepted until the result handshake completes. in_valid while busy is ignored and not queued.
- out_ready asserted outside DONE has no effect.
- Back-to-back: out handshake in DONE returns to IDLE; the next accept occurs at the earliest on the following cycle.
- Arithmetic is unsigned modulo 2^32. The low 32 bits are identical for signed operands. No overflow or carry flag.
- Reset mid-operation (MUL or DONE): discard the partial result and return to reset values on the next edge. No out_valid is produced for the aborted operation.
- Operands and acc are sampled only at the accept edge. Input changes during MUL do not affect the result.

Test Plan:
- Reset, then MUL in1=3, in2=5, acc_en=0, out_ready=1 -> sum=15, mul_cycles=1, N=0, Z=0, out_valid 2 edges after accept.
- MLA in1=3, in2=4, acc=1, acc_en=1 -> sum=13, mul_cycles=1. Repeat with acc=5, acc_en=0 -> sum=12.
- Early termination: in1=2, in2=0x01000000 -> sum=0x02000000, mul_cycles=4. in1=0x10000, in2=0x00010000 -> sum=0, Z=1, mul_cycles=3.
- Wrap and flags:
  - in1=0xFFFFFFFF, in2=0xFFFFFFFF -> sum=0x00000001, mul_cycles=4, N=0.
  - in1=0x40000000, in2=2 -> sum=0x80000000, N=1, mul_cycles=1.
  - in2=0 -> sum=0, Z=1, mul_cycles=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum stable, in_ready=0, and an in_valid pulse during this time is ignored. Release out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-op: start in1=7, in2=0xFFFFFFFF, assert rst during the 2nd MUL cycle -> next edge out_valid=0, sum=0, in_ready=1, no result delivered. A subsequent 6*7 -> 42.
